// File: rtl/ambiente_labirinto.sv
// Maze environment for the wall-following robot: 8x8 wall map, robot pose,
// command execution with fixed latency, wall sensors and step/collision stats.
module ambiente_labirinto #(
  parameter int unsigned PASSO_CICLOS = 4,
  parameter int unsigned X0           = 0,
  parameter int unsigned Y0           = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        avancar,
  input  logic        girar,
  input  logic        map_we,
  input  logic [5:0]  map_addr,
  input  logic        map_data,
  output logic        head,
  output logic        left,
  output logic [2:0]  pos_x,
  output logic [2:0]  pos_y,
  output logic [1:0]  direcao,
  output logic        ocupado,
  output logic        colisao,
  output logic        erro_cmd,
  output logic [15:0] passos,
  output logic [7:0]  colisoes
);

  localparam int unsigned CW = (PASSO_CICLOS > 1) ? $clog2(PASSO_CICLOS) : 1;
  localparam logic [CW-1:0] CNT_CARGA = CW'(PASSO_CICLOS - 1);

  typedef enum logic { OCIOSO, EXECUTANDO } estado_t;
  typedef enum logic { FRENTE, GIRO }       cmd_t;

  estado_t       r_state, w_state_n;
  cmd_t          r_cmd, w_cmd_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_x, r_y, w_x_n, w_y_n;
  logic [1:0]    r_dir, w_dir_n;
  logic          r_colisao, w_colisao_n;
  logic          r_erro, w_erro_n;
  logic [15:0]   r_passos, w_passos_n;
  logic [7:0]    r_colisoes, w_colisoes_n;
  logic [63:0]   r_map;
  logic [6:0]    w_frente, w_esq;
  logic          w_head, w_left;

  // Neighbour cell in heading d: {outside_grid, y, x}
  function automatic logic [6:0] vizinho(input logic [2:0] x, input logic [2:0] y,
                                         input logic [1:0] d);
    logic       fora;
    logic [2:0] nx, ny;
    fora = 1'b0;
    nx   = x;
    ny   = y;
    case (d)
      2'd0:    begin fora = (y == 3'd7); ny = y + 3'd1; end
      2'd1:    begin fora = (x == 3'd7); nx = x + 3'd1; end
      2'd2:    begin fora = (y == 3'd0); ny = y - 3'd1; end
      default: begin fora = (x == 3'd0); nx = x - 3'd1; end
    endcase
    return {fora, ny, nx};
  endfunction

  assign w_frente = vizinho(r_x, r_y, r_dir);
  assign w_esq    = vizinho(r_x, r_y, r_dir + 2'd3);
  assign w_head   = w_frente[6] | r_map[w_frente[5:0]];
  assign w_left   = w_esq[6]    | r_map[w_esq[5:0]];

  always_comb begin
    w_state_n    = r_state;
    w_cmd_n      = r_cmd;
    w_cnt_n      = r_cnt;
    w_x_n        = r_x;
    w_y_n        = r_y;
    w_dir_n      = r_dir;
    w_colisao_n  = 1'b0;
    w_erro_n     = 1'b0;
    w_passos_n   = r_passos;
    w_colisoes_n = r_colisoes;
    case (r_state)
      OCIOSO: begin
        if (avancar && !girar) begin
          w_state_n = EXECUTANDO;
          w_cmd_n   = FRENTE;
          w_cnt_n   = CNT_CARGA;
        end else if (girar && !avancar) begin
          w_state_n = EXECUTANDO;
          w_cmd_n   = GIRO;
          w_cnt_n   = CNT_CARGA;
        end else if (avancar && girar) begin
          w_erro_n = 1'b1;
        end
      end
      default: begin
        if (r_cnt == '0) begin
          w_state_n = OCIOSO;
          if (r_cmd == GIRO) begin
            w_dir_n = r_dir + 2'd1;
          end else if (w_head) begin
            w_colisao_n = 1'b1;
            if (r_colisoes != 8'hFF) w_colisoes_n = r_colisoes + 8'd1;
          end else begin
            w_x_n = w_frente[2:0];
            w_y_n = w_frente[5:3];
            if (r_passos != 16'hFFFF) w_passos_n = r_passos + 16'd1;
          end
        end else begin
          w_cnt_n = r_cnt - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= OCIOSO;
      r_cmd      <= FRENTE;
      r_cnt      <= '0;
      r_x        <= 3'(X0);
      r_y        <= 3'(Y0);
      r_dir      <= 2'd0;
      r_colisao  <= 1'b0;
      r_erro     <= 1'b0;
      r_passos   <= 16'd0;
      r_colisoes <= 8'd0;
    end else begin
      r_state    <= w_state_n;
      r_cmd      <= w_cmd_n;
      r_cnt      <= w_cnt_n;
      r_x        <= w_x_n;
      r_y        <= w_y_n;
      r_dir      <= w_dir_n;
      r_colisao  <= w_colisao_n;
      r_erro     <= w_erro_n;
      r_passos   <= w_passos_n;
      r_colisoes <= w_colisoes_n;
    end
  end

  // Map survives reset; writes to the occupied cell (now or after this edge) are dropped
  always_ff @(posedge clock) begin
    if (map_we && (map_addr != {r_y, r_x}) && (map_addr != {w_y_n, w_x_n}))
      r_map[map_addr] <= map_data;
  end

  assign head     = w_head;
  assign left     = w_left;
  assign pos_x    = r_x;
  assign pos_y    = r_y;
  assign direcao  = r_dir;
  assign ocupado  = (r_state == EXECUTANDO);
  assign colisao  = r_colisao;
  assign erro_cmd = r_erro;
  assign passos   = r_passos;
  assign colisoes = r_colisoes;

endmodule

// File: tb/tb_ambiente_labirinto.sv
// Directed bench for ambiente_labirinto: pose, sensors, timing, collisions,
// command errors, reset behaviour and map write protection.
module tb_ambiente_labirinto;

  localparam int PC = 4;

  logic        clock, reset, avancar, girar, map_we, map_data;
  logic [5:0]  map_addr;
  logic        head, left, ocupado, colisao, erro_cmd;
  logic [2:0]  pos_x, pos_y;
  logic [1:0]  direcao;
  logic [15:0] passos;
  logic [7:0]  colisoes;

  int errors = 0;
  int checks = 0;

  ambiente_labirinto #(.PASSO_CICLOS(PC), .X0(0), .Y0(0)) dut (
    .clock(clock), .reset(reset), .avancar(avancar), .girar(girar),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .head(head), .left(left), .pos_x(pos_x), .pos_y(pos_y),
    .direcao(direcao), .ocupado(ocupado), .colisao(colisao),
    .erro_cmd(erro_cmd), .passos(passos), .colisoes(colisoes)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic map_write(input logic [5:0] a, input logic d);
    map_we = 1'b1; map_addr = a; map_data = d;
    cycle();
    map_we = 1'b0;
  endtask

  // Issue one command; returns right after its commit edge
  task automatic run_cmd(input logic a, input logic g);
    avancar = a; girar = g;
    cycle();
    avancar = 1'b0; girar = 1'b0;
    repeat (PC) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    reset = 1'b1; avancar = 0; girar = 0; map_we = 0; map_addr = 0; map_data = 0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++; if (pos_x !== 3'd0 || pos_y !== 3'd0 || direcao !== 2'd0) begin
      errors++; $display("FAIL reset_pose got=(%0d,%0d,%0d) exp=(0,0,0)", pos_x, pos_y, direcao); end
    checks++; if (ocupado !== 1'b0 || colisao !== 1'b0 || erro_cmd !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%b%b%b exp=000", ocupado, colisao, erro_cmd); end
    checks++; if (passos !== 16'd0 || colisoes !== 8'd0) begin
      errors++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", passos, colisoes); end
    for (int a = 1; a < 64; a++) map_write(6'(a), 1'b0);
    checks++; if (head !== 1'b0 || left !== 1'b1) begin
      errors++; $display("FAIL reset_sensors got=h%b l%b exp=h0 l1", head, left); end
  endtask

  task automatic test_back_to_back();
    int ey;
    logic eo;
    avancar = 1'b1;
    cycle();
    checks++; if (ocupado !== 1'b1 || pos_y !== 3'd0) begin
      errors++; $display("FAIL b2b_start got=o%b y%0d exp=o1 y0", ocupado, pos_y); end
    for (int k = 1; k <= 14; k++) begin
      cycle();
      ey = (k >= 14) ? 3 : (k >= 9) ? 2 : (k >= 4) ? 1 : 0;
      eo = !(k == 4 || k == 9 || k == 14);
      checks++; if (pos_y !== 3'(ey) || ocupado !== eo) begin
        errors++; $display("FAIL b2b k=%0d got=y%0d o%b exp=y%0d o%b", k, pos_y, ocupado, ey, eo); end
    end
    avancar = 1'b0;
    cycle();
    checks++; if (ocupado !== 1'b0 || passos !== 16'd3 || pos_x !== 3'd0) begin
      errors++; $display("FAIL b2b_end got=o%b p%0d x%0d exp=o0 p3 x0", ocupado, passos, pos_x); end
  endtask

  task automatic test_collision();
    do_reset();
    map_write(6'd8, 1'b1);
    checks++; if (head !== 1'b1) begin
      errors++; $display("FAIL col_head got=%b exp=1", head); end
    avancar = 1'b1;
    cycle();
    avancar = 1'b0;
    repeat (PC - 1) cycle();
    checks++; if (colisao !== 1'b0 || ocupado !== 1'b1) begin
      errors++; $display("FAIL col_pre got=c%b o%b exp=c0 o1", colisao, ocupado); end
    cycle();
    checks++; if (colisao !== 1'b1 || colisoes !== 8'd1 || ocupado !== 1'b0) begin
      errors++; $display("FAIL col_pulse got=c%b n%0d o%b exp=c1 n1 o0", colisao, colisoes, ocupado); end
    checks++; if (pos_x !== 3'd0 || pos_y !== 3'd0 || passos !== 16'd0) begin
      errors++; $display("FAIL col_pose got=(%0d,%0d) p%0d exp=(0,0) p0", pos_x, pos_y, passos); end
    cycle();
    checks++; if (colisao !== 1'b0 || colisoes !== 8'd1) begin
      errors++; $display("FAIL col_end got=c%b n%0d exp=c0 n1", colisao, colisoes); end
  endtask

  task automatic test_girar();
    logic [3:0] eh, el;
    eh = 4'b0110;  // per turn: E, S, W, N at (0,0) on an empty map
    el = 4'b1100;
    map_write(6'd8, 1'b0);
    for (int i = 0; i < 4; i++) begin
      girar = 1'b1;
      cycle();
      girar = 1'b0;
      repeat (PC - 1) cycle();
      checks++; if (direcao !== 2'(i) || ocupado !== 1'b1) begin
        errors++; $display("FAIL gir_hold i=%0d got=d%0d o%b exp=d%0d o1", i, direcao, ocupado, i); end
      cycle();
      checks++; if (direcao !== 2'(i + 1) || head !== eh[i] || left !== el[i]) begin
        errors++; $display("FAIL gir i=%0d got=d%0d h%b l%b exp=d%0d h%b l%b",
                           i, direcao, head, left, (i + 1) % 4, eh[i], el[i]); end
    end
  endtask

  task automatic test_erro();
    avancar = 1'b1; girar = 1'b1;
    cycle();
    avancar = 1'b0; girar = 1'b0;
    checks++; if (erro_cmd !== 1'b1 || ocupado !== 1'b0) begin
      errors++; $display("FAIL err_pulse got=e%b o%b exp=e1 o0", erro_cmd, ocupado); end
    cycle();
    checks++; if (erro_cmd !== 1'b0 || ocupado !== 1'b0) begin
      errors++; $display("FAIL err_end got=e%b o%b exp=e0 o0", erro_cmd, ocupado); end
    checks++; if (pos_x !== 3'd0 || pos_y !== 3'd0 || direcao !== 2'd0) begin
      errors++; $display("FAIL err_pose got=(%0d,%0d,%0d) exp=(0,0,0)", pos_x, pos_y, direcao); end
  endtask

  task automatic test_reset_mid();
    map_write(6'd1, 1'b1);
    run_cmd(1'b1, 1'b0);
    checks++; if (pos_y !== 3'd1 || passos !== 16'd1) begin
      errors++; $display("FAIL rm_move got=y%0d p%0d exp=y1 p1", pos_y, passos); end
    map_write(6'd0, 1'b0);
    avancar = 1'b1;
    cycle();
    avancar = 1'b0;
    repeat (2) cycle();
    reset = 1'b1;
    #1;
    checks++; if (ocupado !== 1'b0 || pos_y !== 3'd0 || direcao !== 2'd0 || passos !== 16'd0) begin
      errors++; $display("FAIL rm_async got=o%b y%0d d%0d p%0d exp=o0 y0 d0 p0",
                         ocupado, pos_y, direcao, passos); end
    #1 reset = 1'b0;
    repeat (PC) cycle();
    checks++; if (ocupado !== 1'b0 || pos_y !== 3'd0 || passos !== 16'd0) begin
      errors++; $display("FAIL rm_discard got=o%b y%0d p%0d exp=o0 y0 p0", ocupado, pos_y, passos); end
    run_cmd(1'b0, 1'b1);
    checks++; if (direcao !== 2'd1 || head !== 1'b1) begin
      errors++; $display("FAIL rm_map_kept got=d%0d h%b exp=d1 h1", direcao, head); end
  endtask

  task automatic test_map_write();
    map_write(6'd1, 1'b0);
    checks++; if (head !== 1'b0) begin
      errors++; $display("FAIL mw_clear got=%b exp=0", head); end
    map_write(6'd0, 1'b1);
    run_cmd(1'b1, 1'b0);
    checks++; if (pos_x !== 3'd1 || pos_y !== 3'd0 || passos !== 16'd1) begin
      errors++; $display("FAIL mw_move got=(%0d,%0d) p%0d exp=(1,0) p1", pos_x, pos_y, passos); end
    run_cmd(1'b0, 1'b1);
    run_cmd(1'b0, 1'b1);
    checks++; if (direcao !== 2'd3 || head !== 1'b0) begin
      errors++; $display("FAIL mw_own_dropped got=d%0d h%b exp=d3 h0", direcao, head); end
    map_we = 1'b1; map_addr = 6'd0; map_data = 1'b1;
    checks++; if (head !== 1'b0) begin
      errors++; $display("FAIL mw_pre_edge got=%b exp=0", head); end
    cycle();
    map_we = 1'b0;
    checks++; if (head !== 1'b1) begin
      errors++; $display("FAIL mw_ahead got=%b exp=1", head); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_collision();
    test_girar();
    test_erro();
    test_reset_mid();
    test_map_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
